uart_mode0_rx_fifo: RTL and testbench

UART_MODE0_RX_FIFO -- requirements
Module: uart_mode0_rx_fifo

---
 rtl/uart_mode0_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_mode0_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mode0_rx_fifo.sv
// Synchronous (mode-0) serial receiver with a first-word-fall-through receive FIFO.
// Optional even-parity checking is enabled by defining UART_M0_RX_PARITY_EN.
module uart_mode0_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic                        clk_rx,
  input  logic                        rst,
  input  logic                        ren,
  input  logic                        rxd,
  input  logic                        rd_en,
  input  logic                        clr_ovr,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_done,
  output logic                        overrun,
  output logic                        parity_err
);

`ifdef UART_M0_RX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cur_idx;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  word_nxt;
  logic [DATA_W-1:0]  frame_word;
  logic               commit;
  logic               par_ok;
  logic               good_commit;
  logic               full;
  logic               empty;
  logic               do_pop;
  logic               do_push;
  logic               ovr_set;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  int                 bit_pos;

  // Each sampled bit lands directly in its final data position, so the word
  // including the bit sampled on the commit edge is available combinationally.
  always_comb begin
    cur_idx  = (state == IDLE) ? '0 : bit_cnt;
    bit_pos  = (LSB_FIRST != 0) ? int'(cur_idx) : DATA_W - 1 - int'(cur_idx);
    word_nxt = shift_reg;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == bit_pos) word_nxt[i] = rxd;
    end
  end

  assign commit = ren && (cur_idx == LAST_IDX);

`ifdef UART_M0_RX_PARITY_EN
  assign frame_word = shift_reg;
  assign par_ok     = ((^shift_reg) == rxd);
`else
  assign frame_word = word_nxt;
  assign par_ok     = 1'b1;
`endif

  assign good_commit = commit && par_ok;
  assign full        = (fifo_count == FULL_CNT);
  assign empty       = (fifo_count == '0);
  assign do_pop      = rd_en && !empty;
  assign do_push     = good_commit && (!full || do_pop);
  assign ovr_set     = good_commit && full && !do_pop;
  assign data_valid  = !empty;
  assign data_out    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (!ren) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      shift_reg <= word_nxt;
      if (cur_idx == LAST_IDX) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        state   <= SHIFT;
        bit_cnt <= cur_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rx) begin
    if (do_push) mem[wr_ptr] <= frame_word;
  end

  // Pointers are PTR_W wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_done    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      rx_done <= do_push;
    end
  end

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

`ifdef UART_M0_RX_PARITY_EN
  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst)                     parity_err <= 1'b0;
    else if (commit && !par_ok)  parity_err <= 1'b1;
    else if (clr_ovr)            parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mode0_rx_fifo.sv
// Scoreboard bench for uart_mode0_rx_fifo: popped words are compared by a monitor
// against an expected-word queue; flags and counts are checked directly.
module tb_uart_mode0_rx_fifo;
  localparam int DW = 8;
`ifdef UART_M0_RX_PARITY_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  logic          clk_rx = 1'b0;
  logic          rst = 1'b1;
  logic          ren = 1'b0;
  logic          rxd = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          rd_en_b = 1'b0;
  logic          clr_ovr_b = 1'b0;
  logic [DW-1:0] data_out, data_out_b;
  logic          data_valid, data_valid_b;
  logic [2:0]    fifo_count, fifo_count_b;
  logic          rx_done, rx_done_b, overrun, overrun_b, parity_err, parity_err_b;

  int        checks = 0;
  int        errors = 0;
  logic [7:0] sb[$];

  uart_mode0_rx_fifo #(.DATA_W(DW), .FIFO_DEPTH(4), .LSB_FIRST(1)) dut (
    .clk_rx(clk_rx), .rst(rst), .ren(ren), .rxd(rxd), .rd_en(rd_en), .clr_ovr(clr_ovr),
    .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count),
    .rx_done(rx_done), .overrun(overrun), .parity_err(parity_err));

  uart_mode0_rx_fifo #(.DATA_W(DW), .FIFO_DEPTH(4), .LSB_FIRST(0)) dut_msb (
    .clk_rx(clk_rx), .rst(rst), .ren(ren), .rxd(rxd), .rd_en(rd_en_b), .clr_ovr(clr_ovr_b),
    .data_out(data_out_b), .data_valid(data_valid_b), .fifo_count(fifo_count_b),
    .rx_done(rx_done_b), .overrun(overrun_b), .parity_err(parity_err_b));

  always #5 clk_rx = ~clk_rx;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveBit(input logic b, input logic rd);
    @(posedge clk_rx); #2;
    ren = 1'b1; rxd = b; rd_en = rd; clr_ovr = 1'b0;
  endtask

  // Sends one frame LSB first, appending even parity (optionally corrupted) when enabled.
  task automatic applyStimulus(input logic [7:0] w, input logic rd_last, input logic bad_par);
    logic [8:0] fw;
    fw = {(^w) ^ bad_par, w};
    for (int i = 0; i < FLEN; i++) driveBit(fw[i], rd_last && (i == FLEN - 1));
  endtask

  task automatic idleCycle();
    @(posedge clk_rx); #2;
    ren = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    @(negedge clk_rx);
  endtask

  task automatic popWords(input int n);
    @(posedge clk_rx); #2;
    ren = 1'b0; rd_en = 1'b1;
    repeat (n - 1) @(posedge clk_rx);
    @(posedge clk_rx); #2;
    rd_en = 1'b0;
    @(negedge clk_rx);
  endtask

  // Monitor: every accepted pop must return the oldest expected word.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk_rx);
      if (!rst && rd_en && data_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL pop_unexpected: got %0h, expected no word", data_out);
        end else begin
          exp = sb.pop_front();
          checkOutput("pop_data", 32'(data_out), 32'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    @(negedge clk_rx);
    checkOutput("rst_valid", 32'(data_valid), 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_data", 32'(data_out), 0);
    checkOutput("rst_done", 32'(rx_done), 0);
    checkOutput("rst_ovr", 32'(overrun), 0);
    checkOutput("rst_par", 32'(parity_err), 0);
    @(posedge clk_rx); #2;
    rst = 1'b0;

    // Single frame: bits 1,0,1,0,0,0,0,0
    applyStimulus(8'h05, 1'b0, 1'b0);
    sb.push_back(8'h05);
    idleCycle();
    checkOutput("f05_done", 32'(rx_done), 1);
    checkOutput("f05_data", 32'(data_out), 32'h05);
    checkOutput("f05_count", 32'(fifo_count), 1);
    checkOutput("f05_valid", 32'(data_valid), 1);
    checkOutput("msb_data", 32'(data_out_b), 32'hA0);
    @(negedge clk_rx);
    checkOutput("f05_done_pulse", 32'(rx_done), 0);
    popWords(1);
    checkOutput("pop_count0", 32'(fifo_count), 0);
    checkOutput("pop_valid0", 32'(data_valid), 0);

    // Reading an empty FIFO must not underflow.
    popWords(2);
    checkOutput("empty_rd_count", 32'(fifo_count), 0);

    // Five back-to-back frames into a four-deep FIFO.
    applyStimulus(8'h11, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b0, 1'b0);
    applyStimulus(8'h44, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b0);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
    idleCycle();
    checkOutput("ovr_done", 32'(rx_done), 0);
    checkOutput("ovr_count", 32'(fifo_count), 4);
    checkOutput("ovr_flag", 32'(overrun), 1);
    @(posedge clk_rx); #2;
    clr_ovr = 1'b1;
    @(posedge clk_rx); #2;
    clr_ovr = 1'b0;
    @(negedge clk_rx);
    checkOutput("ovr_cleared", 32'(overrun), 0);
    popWords(4);
    checkOutput("ovr_drained", 32'(fifo_count), 0);

    // Partial frame aborted by ren low, then a full frame.
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    driveBit(1'b1, 1'b0);
    @(posedge clk_rx); #2;
    ren = 1'b0;
    applyStimulus(8'hC3, 1'b0, 1'b0);
    sb.push_back(8'hC3);
    idleCycle();
    checkOutput("abort_count", 32'(fifo_count), 1);
    checkOutput("abort_data", 32'(data_out), 32'hC3);
    popWords(1);

    // Full FIFO with a pop on the commit edge of the fifth word.
    applyStimulus(8'h61, 1'b0, 1'b0);
    applyStimulus(8'h72, 1'b0, 1'b0);
    applyStimulus(8'h83, 1'b0, 1'b0);
    applyStimulus(8'h94, 1'b0, 1'b0);
    sb.push_back(8'h61); sb.push_back(8'h72); sb.push_back(8'h83); sb.push_back(8'h94);
    applyStimulus(8'h99, 1'b1, 1'b0);
    sb.push_back(8'h99);
    idleCycle();
    checkOutput("rw_ovr", 32'(overrun), 0);
    checkOutput("rw_count", 32'(fifo_count), 4);
    checkOutput("rw_done", 32'(rx_done), 1);
    popWords(4);

    // Asynchronous reset mid-frame with a word held in the FIFO.
    applyStimulus(8'h5A, 1'b0, 1'b0);
    idleCycle();
    driveBit(1'b1, 1'b0);
    driveBit(1'b0, 1'b0);
    driveBit(1'b1, 1'b0);
    #1;
    rst = 1'b1; ren = 1'b0;
    #1;
    checkOutput("arst_count", 32'(fifo_count), 0);
    checkOutput("arst_valid", 32'(data_valid), 0);
    checkOutput("arst_data", 32'(data_out), 0);
    sb.delete();
    @(posedge clk_rx); #2;
    rst = 1'b0;
    applyStimulus(8'hA6, 1'b0, 1'b0);
    sb.push_back(8'hA6);
    idleCycle();
    checkOutput("post_rst_count", 32'(fifo_count), 1);
    checkOutput("post_rst_data", 32'(data_out), 32'hA6);
    popWords(1);

`ifdef UART_M0_RX_PARITY_EN
    applyStimulus(8'h03, 1'b0, 1'b1);
    idleCycle();
    checkOutput("par_bad_flag", 32'(parity_err), 1);
    checkOutput("par_bad_count", 32'(fifo_count), 0);
    checkOutput("par_bad_done", 32'(rx_done), 0);
    applyStimulus(8'h03, 1'b0, 1'b0);
    sb.push_back(8'h03);
    idleCycle();
    checkOutput("par_ok_count", 32'(fifo_count), 1);
    checkOutput("par_ok_done", 32'(rx_done), 1);
    popWords(1);
`else
    checkOutput("par_tied", 32'(parity_err), 0);
`endif

    checkOutput("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
